// File: rtl/midi_voice_alloc_pkg.sv
// Shared definitions for the MIDI voice allocator: payload widths, voice
// limits and the note-on allocation decision type.
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 7
`endif
`ifndef MIDI_MAX_VOICES
`define MIDI_MAX_VOICES 16
`endif

package midi_voice_alloc_pkg;

  localparam int unsigned MIDI_NOTE_W     = `MIDI_PAYLOAD_BITS;
  localparam int unsigned MIDI_VOICES_MAX = `MIDI_MAX_VOICES;

  // Outcome of the note-on priority search for the current cycle.
  typedef enum logic [1:0] {
    ALLOC_NONE  = 2'd0,
    ALLOC_MATCH = 2'd1,
    ALLOC_FREE  = 2'd2,
    ALLOC_STEAL = 2'd3
  } alloc_kind_e;

endpackage

// File: rtl/midi_voice_alloc_voice_age_lru.sv
// Least-recently-triggered tracker. Each voice holds an age rank; the ranks
// always form a permutation of 0..NUM_VOICES-1 with 0 the newest.
// Ports:
//   clk_i, nrst_i   clock, asynchronous active-low reset
//   touch_vld       a voice is being (re)triggered this cycle
//   touch_idx       index of that voice
//   oldest_idx_c    index of the voice whose rank is NUM_VOICES-1
module voice_age_lru #(
  parameter  int unsigned NUM_VOICES = 4,
  localparam int unsigned AGE_BITS   = $clog2(NUM_VOICES)
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic                touch_vld,
  input  logic [AGE_BITS-1:0] touch_idx,
  output logic [AGE_BITS-1:0] oldest_idx_c
);

  logic [AGE_BITS-1:0] age_q [NUM_VOICES];

  // Touched voice becomes newest; everything newer than it ages by one.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        age_q[v] <= AGE_BITS'(v);
      end
    end else if (touch_vld) begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        if (AGE_BITS'(v) == touch_idx) begin
          age_q[v] <= '0;
        end else if (age_q[v] < age_q[touch_idx]) begin
          age_q[v] <= age_q[v] + AGE_BITS'(1);
        end
      end
    end
  end

  // Exactly one voice carries the maximum rank.
  always_comb begin
    oldest_idx_c = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      if (age_q[v] == AGE_BITS'(NUM_VOICES - 1)) begin
        oldest_idx_c = AGE_BITS'(v);
      end
    end
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice scheduler: maps parser note-on/note-off strobes onto
// NUM_VOICES oscillator voices, retriggering a matching voice, else taking
// the lowest free voice, else stealing the least-recently-triggered one.
// Ports:
//   clk_i, nrst_i      clock, asynchronous active-low reset
//   note_i             note number, qualified by the strobes
//   noteOnStrb_i       note-on request
//   noteOffStrb_i      note-off request
//   panic_i            all-notes-off, overrides both strobes
//   voiceNote_o        per-voice note, voice v at [v*W +: W]
//   voiceActive_o      per-voice gate
//   voiceTrigStrb_o    one-cycle (re)assignment pulse per voice
//   stealStrb_o        one-cycle pulse when an active voice was taken
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 7
`endif

module midi_voice_alloc
  import midi_voice_alloc_pkg::*;
#(
  parameter  int unsigned NUM_VOICES = 4,
  localparam int unsigned AGE_BITS   = $clog2(NUM_VOICES)
) (
  input  logic                                    clk_i,
  input  logic                                    nrst_i,
  input  logic [`MIDI_PAYLOAD_BITS-1:0]            note_i,
  input  logic                                    noteOnStrb_i,
  input  logic                                    noteOffStrb_i,
  input  logic                                    panic_i,
  output logic [NUM_VOICES*`MIDI_PAYLOAD_BITS-1:0] voiceNote_o,
  output logic [NUM_VOICES-1:0]                   voiceActive_o,
  output logic [NUM_VOICES-1:0]                   voiceTrigStrb_o,
  output logic                                    stealStrb_o
);

  localparam int unsigned NOTE_W = MIDI_NOTE_W;
  localparam int unsigned IDX_W  = AGE_BITS;

  if (NUM_VOICES < 2 || NUM_VOICES > MIDI_VOICES_MAX) begin : g_bad_num_voices
    $error("midi_voice_alloc: NUM_VOICES out of range");
  end

  logic [NUM_VOICES*NOTE_W-1:0] note_q, note_d;
  logic [NUM_VOICES-1:0]        active_q, active_d;
  logic [NUM_VOICES-1:0]        trig_q, trig_d;
  logic                         steal_q, steal_d;

  logic [NUM_VOICES-1:0] match_c;
  logic                  match_any_c, free_any_c;
  logic [IDX_W-1:0]      match_idx_c, free_idx_c, oldest_idx_c, sel_idx_c;
  alloc_kind_e           kind_c;

  voice_age_lru #(
    .NUM_VOICES (NUM_VOICES)
  ) u_age (
    .clk_i        (clk_i),
    .nrst_i       (nrst_i),
    .touch_vld    (kind_c != ALLOC_NONE),
    .touch_idx    (sel_idx_c),
    .oldest_idx_c (oldest_idx_c)
  );

  // Sounding-note match and free-voice search; descending scan so the
  // lowest index wins.
  always_comb begin
    match_c     = '0;
    match_any_c = 1'b0;
    match_idx_c = '0;
    free_any_c  = 1'b0;
    free_idx_c  = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      match_c[v] = active_q[v] && (note_q[v*NOTE_W +: NOTE_W] == note_i);
    end
    for (int v = int'(NUM_VOICES) - 1; v >= 0; v--) begin
      if (match_c[v]) begin
        match_any_c = 1'b1;
        match_idx_c = IDX_W'(v);
      end
      if (!active_q[v]) begin
        free_any_c = 1'b1;
        free_idx_c = IDX_W'(v);
      end
    end
  end

  // Note-on priority: match, then free, then steal the oldest.
  always_comb begin
    kind_c    = ALLOC_NONE;
    sel_idx_c = match_idx_c;
    if (!panic_i && noteOnStrb_i) begin
      if (match_any_c) begin
        kind_c    = ALLOC_MATCH;
        sel_idx_c = match_idx_c;
      end else if (free_any_c) begin
        kind_c    = ALLOC_FREE;
        sel_idx_c = free_idx_c;
      end else begin
        kind_c    = ALLOC_STEAL;
        sel_idx_c = oldest_idx_c;
      end
    end
  end

  // Next voice state; note-off only applies when no note-on is taken.
  always_comb begin
    note_d   = note_q;
    active_d = active_q;
    trig_d   = '0;
    steal_d  = 1'b0;
    if (panic_i) begin
      active_d = '0;
    end else if (kind_c != ALLOC_NONE) begin
      note_d[int'(sel_idx_c)*NOTE_W +: NOTE_W] = note_i;
      active_d[sel_idx_c] = 1'b1;
      trig_d[sel_idx_c]   = 1'b1;
      steal_d             = (kind_c == ALLOC_STEAL);
    end else if (noteOffStrb_i) begin
      active_d = active_q & ~match_c;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      note_q   <= '0;
      active_q <= '0;
      trig_q   <= '0;
      steal_q  <= 1'b0;
    end else begin
      note_q   <= note_d;
      active_q <= active_d;
      trig_q   <= trig_d;
      steal_q  <= steal_d;
    end
  end

  assign voiceNote_o     = note_q;
  assign voiceActive_o   = active_q;
  assign voiceTrigStrb_o = trig_q;
  assign stealStrb_o     = steal_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed bench for midi_voice_alloc with four voices.
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 7
`endif

module tb_midi_voice_alloc;

  localparam int unsigned NV = 4;
  localparam int unsigned W  = `MIDI_PAYLOAD_BITS;

  logic            clk_i = 1'b0;
  logic            nrst_i = 1'b0;
  logic [W-1:0]    note_i = '0;
  logic            noteOnStrb_i = 1'b0;
  logic            noteOffStrb_i = 1'b0;
  logic            panic_i = 1'b0;
  logic [NV*W-1:0] voiceNote_o;
  logic [NV-1:0]   voiceActive_o;
  logic [NV-1:0]   voiceTrigStrb_o;
  logic            stealStrb_o;

  int n_cmp = 0;
  int n_err = 0;

  midi_voice_alloc #(.NUM_VOICES(NV)) dut (
    .clk_i           (clk_i),
    .nrst_i          (nrst_i),
    .note_i          (note_i),
    .noteOnStrb_i    (noteOnStrb_i),
    .noteOffStrb_i   (noteOffStrb_i),
    .panic_i         (panic_i),
    .voiceNote_o     (voiceNote_o),
    .voiceActive_o   (voiceActive_o),
    .voiceTrigStrb_o (voiceTrigStrb_o),
    .stealStrb_o     (stealStrb_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] vnote(input int v);
    return voiceNote_o[v*W +: W];
  endfunction

  // One-cycle request; returns at the falling edge after the capturing edge.
  task automatic strobe(input logic on, input logic off, input logic pan, input int n);
    @(negedge clk_i);
    noteOnStrb_i  = on;
    noteOffStrb_i = off;
    panic_i       = pan;
    note_i        = W'(n);
    @(negedge clk_i);
    noteOnStrb_i  = 1'b0;
    noteOffStrb_i = 1'b0;
    panic_i       = 1'b0;
    note_i        = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    nrst_i = 1'b0;
    @(negedge clk_i);
    nrst_i = 1'b1;
  endtask

  task automatic fill4();
    int notes [4] = '{60, 62, 64, 65};
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0, 1'b0, notes[i]);
  endtask

  task automatic test_reset();
    nrst_i = 1'b0;
    #2;
    n_cmp++;
    if ({voiceNote_o, voiceActive_o, voiceTrigStrb_o, stealStrb_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got note=%h act=%b trig=%b steal=%b, expected all 0",
               voiceNote_o, voiceActive_o, voiceTrigStrb_o, stealStrb_o);
    end
    @(negedge clk_i);
    nrst_i = 1'b1;
  endtask

  task automatic test_first_note();
    strobe(1'b1, 1'b0, 1'b0, 60);
    n_cmp++;
    if (vnote(0) !== W'(60)) begin
      n_err++; $display("FAIL first_note_v0: got %0d expected 60", vnote(0));
    end
    n_cmp++;
    if ({voiceActive_o, voiceTrigStrb_o, stealStrb_o} !== {4'b0001, 4'b0001, 1'b0}) begin
      n_err++; $display("FAIL first_note_flags: got act=%b trig=%b steal=%b expected 0001 0001 0",
                        voiceActive_o, voiceTrigStrb_o, stealStrb_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if ({voiceTrigStrb_o, stealStrb_o, voiceActive_o} !== {4'b0000, 1'b0, 4'b0001}) begin
      n_err++; $display("FAIL strobe_deassert: got trig=%b steal=%b act=%b expected 0000 0 0001",
                        voiceTrigStrb_o, stealStrb_o, voiceActive_o);
    end
  endtask

  task automatic test_fill();
    strobe(1'b1, 1'b0, 1'b0, 62);
    strobe(1'b1, 1'b0, 1'b0, 64);
    strobe(1'b1, 1'b0, 1'b0, 65);
    n_cmp++;
    if (voiceNote_o !== {7'd65, 7'd64, 7'd62, 7'd60}) begin
      n_err++; $display("FAIL fill_notes: got %h expected %h", voiceNote_o, {7'd65, 7'd64, 7'd62, 7'd60});
    end
    n_cmp++;
    if ({voiceActive_o, voiceTrigStrb_o, stealStrb_o} !== {4'b1111, 4'b1000, 1'b0}) begin
      n_err++; $display("FAIL fill_flags: got act=%b trig=%b steal=%b expected 1111 1000 0",
                        voiceActive_o, voiceTrigStrb_o, stealStrb_o);
    end
  endtask

  task automatic test_steal();
    strobe(1'b1, 1'b0, 1'b0, 67);
    n_cmp++;
    if ({vnote(0), voiceTrigStrb_o, stealStrb_o} !== {7'd67, 4'b0001, 1'b1}) begin
      n_err++; $display("FAIL steal_first: got v0=%0d trig=%b steal=%b expected 67 0001 1",
                        vnote(0), voiceTrigStrb_o, stealStrb_o);
    end
    strobe(1'b1, 1'b0, 1'b0, 69);
    n_cmp++;
    if ({vnote(1), voiceTrigStrb_o, stealStrb_o, voiceActive_o} !== {7'd69, 4'b0010, 1'b1, 4'b1111}) begin
      n_err++; $display("FAIL steal_second: got v1=%0d trig=%b steal=%b act=%b expected 69 0010 1 1111",
                        vnote(1), voiceTrigStrb_o, stealStrb_o, voiceActive_o);
    end
  endtask

  task automatic test_note_off();
    do_reset();
    fill4();
    strobe(1'b0, 1'b1, 1'b0, 99);
    n_cmp++;
    if ({voiceActive_o, voiceTrigStrb_o} !== {4'b1111, 4'b0000}) begin
      n_err++; $display("FAIL off_not_sounding: got act=%b trig=%b expected 1111 0000",
                        voiceActive_o, voiceTrigStrb_o);
    end
    strobe(1'b0, 1'b1, 1'b0, 62);
    n_cmp++;
    if ({voiceActive_o, voiceTrigStrb_o, vnote(1)} !== {4'b1101, 4'b0000, 7'd62}) begin
      n_err++; $display("FAIL off_release: got act=%b trig=%b v1=%0d expected 1101 0000 62",
                        voiceActive_o, voiceTrigStrb_o, vnote(1));
    end
    strobe(1'b1, 1'b0, 1'b0, 70);
    n_cmp++;
    if ({voiceActive_o, voiceTrigStrb_o, stealStrb_o, vnote(1)} !== {4'b1111, 4'b0010, 1'b0, 7'd70}) begin
      n_err++; $display("FAIL reuse_free: got act=%b trig=%b steal=%b v1=%0d expected 1111 0010 0 70",
                        voiceActive_o, voiceTrigStrb_o, stealStrb_o, vnote(1));
    end
  endtask

  task automatic test_retrigger();
    strobe(1'b1, 1'b0, 1'b0, 64);
    n_cmp++;
    if ({voiceTrigStrb_o, stealStrb_o, voiceActive_o} !== {4'b0100, 1'b0, 4'b1111}) begin
      n_err++; $display("FAIL retrig_flags: got trig=%b steal=%b act=%b expected 0100 0 1111",
                        voiceTrigStrb_o, stealStrb_o, voiceActive_o);
    end
    n_cmp++;
    if (voiceNote_o !== {7'd65, 7'd64, 7'd70, 7'd60}) begin
      n_err++; $display("FAIL retrig_notes: got %h expected %h", voiceNote_o, {7'd65, 7'd64, 7'd70, 7'd60});
    end
    // Ranks now v0=3 v1=1 v2=0 v3=2: 71 takes v0, then 72 must take v3.
    strobe(1'b1, 1'b0, 1'b0, 71);
    n_cmp++;
    if ({voiceTrigStrb_o, stealStrb_o} !== {4'b0001, 1'b1}) begin
      n_err++; $display("FAIL age_steal_a: got trig=%b steal=%b expected 0001 1", voiceTrigStrb_o, stealStrb_o);
    end
    strobe(1'b1, 1'b0, 1'b0, 72);
    n_cmp++;
    if ({voiceTrigStrb_o, stealStrb_o, vnote(3)} !== {4'b1000, 1'b1, 7'd72}) begin
      n_err++; $display("FAIL age_steal_b: got trig=%b steal=%b v3=%0d expected 1000 1 72",
                        voiceTrigStrb_o, stealStrb_o, vnote(3));
    end
  endtask

  task automatic test_on_off_panic();
    do_reset();
    strobe(1'b1, 1'b1, 1'b0, 50);
    n_cmp++;
    if ({voiceActive_o, voiceTrigStrb_o, vnote(0)} !== {4'b0001, 4'b0001, 7'd50}) begin
      n_err++; $display("FAIL on_off_same_cycle: got act=%b trig=%b v0=%0d expected 0001 0001 50",
                        voiceActive_o, voiceTrigStrb_o, vnote(0));
    end
    strobe(1'b1, 1'b0, 1'b1, 51);
    n_cmp++;
    if ({voiceActive_o, voiceTrigStrb_o, stealStrb_o, vnote(0), vnote(1)} !==
        {4'b0000, 4'b0000, 1'b0, 7'd50, 7'd0}) begin
      n_err++; $display("FAIL panic: got act=%b trig=%b steal=%b v0=%0d v1=%0d expected 0000 0000 0 50 0",
                        voiceActive_o, voiceTrigStrb_o, stealStrb_o, vnote(0), vnote(1));
    end
    strobe(1'b1, 1'b0, 1'b0, 51);
    n_cmp++;
    if ({voiceActive_o, voiceTrigStrb_o, vnote(0)} !== {4'b0001, 4'b0001, 7'd51}) begin
      n_err++; $display("FAIL after_panic: got act=%b trig=%b v0=%0d expected 0001 0001 51",
                        voiceActive_o, voiceTrigStrb_o, vnote(0));
    end
  endtask

  task automatic test_async_reset();
    strobe(1'b1, 1'b0, 1'b0, 53);
    n_cmp++;
    if ({voiceActive_o, voiceTrigStrb_o, vnote(1)} !== {4'b0011, 4'b0010, 7'd53}) begin
      n_err++; $display("FAIL pre_reset: got act=%b trig=%b v1=%0d expected 0011 0010 53",
                        voiceActive_o, voiceTrigStrb_o, vnote(1));
    end
    @(posedge clk_i);
    #2 nrst_i = 1'b0;
    #1;
    n_cmp++;
    if ({voiceNote_o, voiceActive_o, voiceTrigStrb_o, stealStrb_o} !== '0) begin
      n_err++; $display("FAIL async_reset: got note=%h act=%b trig=%b steal=%b expected all 0",
                        voiceNote_o, voiceActive_o, voiceTrigStrb_o, stealStrb_o);
    end
    @(negedge clk_i);
    nrst_i = 1'b1;
    strobe(1'b1, 1'b0, 1'b0, 55);
    n_cmp++;
    if ({voiceActive_o, voiceTrigStrb_o, stealStrb_o, voiceNote_o} !==
        {4'b0001, 4'b0001, 1'b0, {7'd0, 7'd0, 7'd0, 7'd55}}) begin
      n_err++; $display("FAIL post_reset: got act=%b trig=%b steal=%b note=%h expected 0001 0001 0 %h",
                        voiceActive_o, voiceTrigStrb_o, stealStrb_o, voiceNote_o,
                        {7'd0, 7'd0, 7'd0, 7'd55});
    end
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_fill();
    test_steal();
    test_note_off();
    test_retrigger();
    test_on_off_panic();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
